// File: rtl/feed_schedule_timer.sv
// Minute-of-day clock with a 4-entry meal table driving timesup/newday.
// Optional MISSED_CNT_EN adds a saturating missed-meal counter output.
module feed_schedule_timer #(
  parameter int TICKS_PER_MIN = 600,
  parameter int HOLD_CYCLES   = 64,
  parameter int MIN_PER_DAY   = 1440
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_en,
  input  logic        time_set_en,
  input  logic [10:0] time_set_min,
  input  logic        meal_wr_en,
  input  logic [1:0]  meal_wr_idx,
  input  logic [10:0] meal_wr_min,
  input  logic        meal_wr_valid,
  input  logic        food_gate,
  output logic        timesup,
  output logic        newday,
  output logic [10:0] cur_min,
  output logic [1:0]  meal_idx
`ifdef MISSED_CNT_EN
  ,
  output logic [7:0]  missed_cnt
`endif
);

  localparam int PW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICKS_PER_MIN - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [10:0]   MIN_MAX  = 11'(MIN_PER_DAY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACKED} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [10:0]     min_q, min_d;
  logic            tick_q, tick_d;
  logic            newday_q, newday_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [1:0]      idx_q, idx_d;
  logic [10:0]     tbl_min_q [4];
  logic            tbl_v_q   [4];
  logic            eval, hit, match;
  logic [1:0]      hit_idx;

  always_comb begin
    pre_d  = pre_q;
    min_d  = min_q;
    tick_d = 1'b0;
    if (time_set_en) begin
      pre_d = '0;
      min_d = (time_set_min <= MIN_MAX) ? time_set_min : '0;
    end else if (run_en) begin
      if (pre_q == PRE_MAX) begin
        pre_d  = '0;
        tick_d = 1'b1;
        min_d  = (min_q == MIN_MAX) ? '0 : min_q + 11'd1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // Match is judged the cycle after the tick, against the new minute.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (tbl_v_q[i] && tbl_min_q[i] == min_q) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

  assign eval     = tick_q & ~time_set_en;
  assign match    = eval & hit;
  assign newday_d = eval & (min_q == '0);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (match) begin
          state_d = WAIT;
          hold_d  = '0;
          idx_d   = hit_idx;
        end
      end
      WAIT: begin
        if (food_gate) state_d = ACKED;
        else if (hold_q == HOLD_MAX) state_d = IDLE;
        else hold_d = hold_q + HW'(1);
      end
      ACKED: begin
        if (!food_gate) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      min_q    <= '0;
      tick_q   <= 1'b0;
      newday_q <= 1'b0;
      hold_q   <= '0;
      idx_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        tbl_min_q[i] <= '0;
        tbl_v_q[i]   <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      min_q    <= min_d;
      tick_q   <= tick_d;
      newday_q <= newday_d;
      hold_q   <= hold_d;
      idx_q    <= idx_d;
      if (meal_wr_en) begin
        tbl_min_q[meal_wr_idx] <= meal_wr_min;
        tbl_v_q[meal_wr_idx]   <= meal_wr_valid;
      end
    end
  end

  assign timesup  = (state_q == WAIT);
  assign newday   = newday_q;
  assign cur_min  = min_q;
  assign meal_idx = idx_q;

`ifdef MISSED_CNT_EN
  logic       timeout, ignored;
  logic [8:0] miss_sum;
  logic [7:0] miss_q, miss_d;

  assign timeout = (state_q == WAIT) & ~food_gate & (hold_q == HOLD_MAX);
  assign ignored = match & (state_q != IDLE);

  always_comb begin
    miss_sum = {1'b0, miss_q} + {8'd0, timeout} + {8'd0, ignored};
    miss_d   = miss_q;
    if (newday_q) miss_d = '0;
    else if (miss_sum > 9'd255) miss_d = 8'hFF;
    else miss_d = miss_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) miss_q <= '0;
    else miss_q <= miss_d;
  end

  assign missed_cnt = miss_q;
`else
  // Timeouts drop back to IDLE with no record kept.
`endif

endmodule
